lsl_seq_divider: RTL and testbench

//  Multi-cycle restoring integer divider; counterpart of the Booth multiplier datapath.
//  The multiplier shifts its accumulator right each step; this divider shifts {remainder,quotient} left.

---
 rtl/lsl_seq_divider_if.sv | 24 ++
 rtl/lsl_seq_divider.sv | 151 +++++++++++++++
 tb/tb_lsl_seq_divider.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsl_seq_divider_if.sv
// Handshake and operand/result bundle for lsl_seq_divider.
// The master drives operands and control; the slave (the divider) returns status and results.
interface lsl_seq_divider_if #(
    parameter int WIDTH = 64
);
    logic             op_start;
    logic             op_clear;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             op_done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output op_start, op_clear, dividend, divisor,
        input  op_done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  op_start, op_clear, dividend, divisor,
        output op_done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/lsl_seq_divider.sv
// Restoring divider producing one quotient bit per clock by shifting {R,Q} left.
// Define SIGNED_DIV_EN for two's-complement operands (adds a one-clock FIX state for sign correction).
module lsl_seq_divider #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input logic              clk,
    input logic              reset_n,
    lsl_seq_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] r_work, q_work, d_work;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] quot, rem;
    logic             dz;

    logic             start_ok;
    logic             zero_div;
    logic             last_step;
    logic [WIDTH:0]   trial;
    logic             take;
    logic [WIDTH-1:0] r_step, q_step;
    logic [WIDTH-1:0] load_dividend, load_divisor;

`ifdef SIGNED_DIV_EN
    logic sign_q, sign_r;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign load_dividend = mag(bus.dividend);
    assign load_divisor  = mag(bus.divisor);
`else
    assign load_dividend = bus.dividend;
    assign load_divisor  = bus.divisor;
`endif

    // op_clear always wins over op_start
    assign start_ok  = bus.op_start & ~bus.op_clear;
    assign zero_div  = (bus.divisor == '0);
    assign last_step = (count == CNT_W'(WIDTH - 1));

    assign trial  = {r_work, q_work[WIDTH-1]};
    assign take   = (trial >= {1'b0, d_work});
    assign r_step = take ? WIDTH'(trial - {1'b0, d_work}) : trial[WIDTH-1:0];
    assign q_step = {q_work[WIDTH-2:0], take};

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = zero_div ? DONE : EXEC;
            EXEC: begin
                if (bus.op_clear) state_nxt = IDLE;
                else if (last_step) begin
`ifdef SIGNED_DIV_EN
                    state_nxt = FIX;
`else
                    state_nxt = DONE;
`endif
                end
            end
            FIX:  state_nxt = bus.op_clear ? IDLE : DONE;
            DONE: if (bus.op_clear) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers and the visible result registers are kept apart so
    // quotient/remainder never show partial results during EXEC.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_work <= '0;
            q_work <= '0;
            d_work <= '0;
            count  <= '0;
            quot   <= '0;
            rem    <= '0;
            dz     <= 1'b0;
`ifdef SIGNED_DIV_EN
            sign_q <= 1'b0;
            sign_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        if (zero_div) begin
                            quot <= '1;
                            rem  <= bus.dividend;
                            dz   <= 1'b1;
                        end else begin
                            r_work <= '0;
                            q_work <= load_dividend;
                            d_work <= load_divisor;
                            count  <= '0;
`ifdef SIGNED_DIV_EN
                            sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            sign_r <= bus.dividend[WIDTH-1];
`endif
                        end
                    end
                end
                EXEC: begin
                    if (bus.op_clear) begin
                        quot <= '0;
                        rem  <= '0;
                    end else begin
                        r_work <= r_step;
                        q_work <= q_step;
                        count  <= count + CNT_W'(1);
`ifndef SIGNED_DIV_EN
                        if (last_step) begin
                            quot <= q_step;
                            rem  <= r_step;
                        end
`endif
                    end
                end
                FIX: begin
                    if (bus.op_clear) begin
                        quot <= '0;
                        rem  <= '0;
                    end else begin
`ifdef SIGNED_DIV_EN
                        quot <= sign_q ? -q_work : q_work;
                        rem  <= sign_r ? -r_work : r_work;
`else
                        quot <= q_work;
                        rem  <= r_work;
`endif
                    end
                end
                DONE: if (bus.op_clear) dz <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.op_done     = (state == DONE);
    assign bus.div_by_zero = dz;
    assign bus.quotient    = quot;
    assign bus.remainder   = rem;
endmodule

// File: tb/tb_lsl_seq_divider.sv
// Self-checking bench for lsl_seq_divider: per-cycle comparison against a transaction-level model,
// plus directed scenarios with hand-computed results.
module tb_lsl_seq_divider;
    localparam int W = 64;
`ifdef SIGNED_DIV_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    lsl_seq_divider_if #(.WIDTH(W)) bus ();
    lsl_seq_divider #(.WIDTH(W), .CNT_W(7)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Arithmetic reference for one division.
    task automatic golden(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r);
`ifdef SIGNED_DIV_EN
        logic [W-1:0] ua, ub, uq, ur;
        ua = a[W-1] ? -a : a;
        ub = b[W-1] ? -b : b;
        uq = ua / ub;
        ur = ua % ub;
        q = (a[W-1] ^ b[W-1]) ? -uq : uq;
        r = a[W-1] ? -ur : ur;
`else
        q = a / b;
        r = a % b;
`endif
    endtask

    // Transaction model: idle / busy with countdown / result held.
    bit           m_busy = 0, m_done = 0, m_dz = 0;
    int           m_left = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q, p_r;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_dz = 0; m_left = 0; m_q = '0; m_r = '0;
        end else if (m_busy) begin
            if (bus.op_clear) begin
                m_busy = 0; m_q = '0; m_r = '0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r;
                end
            end
        end else if (m_done) begin
            if (bus.op_clear) begin
                m_done = 0; m_dz = 0;
            end
        end else if (bus.op_start && !bus.op_clear) begin
            if (bus.divisor == '0) begin
                m_done = 1; m_dz = 1; m_q = '1; m_r = bus.dividend;
            end else begin
                m_busy = 1; m_left = LAT;
                golden(bus.dividend, bus.divisor, p_q, p_r);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("op_done", W'(bus.op_done), W'(m_done));
            chk("div_by_zero", W'(bus.div_by_zero), W'(m_dz));
            chk("quotient", bus.quotient, m_q);
            chk("remainder", bus.remainder, m_r);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.op_start = 1'b1;
        tick();
        bus.op_start = 1'b0;
    endtask

    task automatic clear_op(input bit with_start);
        bus.op_clear = 1'b1;
        bus.op_start = with_start;
        tick();
        bus.op_clear = 1'b0;
        bus.op_start = 1'b0;
    endtask

    // Returns the number of edges after the sampling edge until op_done is seen.
    task automatic wait_done(input bit noise, output int n);
        n = 0;
        while (!bus.op_done && n < 300) begin
            if (noise && $urandom_range(0, 15) == 0) begin
                bus.op_start = 1'b1;
                bus.dividend = {$urandom, $urandom};
                bus.divisor  = {$urandom, $urandom};
            end
            tick();
            bus.op_start = 1'b0;
            n++;
        end
        n_cmp++;
        if (!bus.op_done) begin
            n_bad++;
            $display("FAIL wait_done timeout: got op_done=0 after %0d edges, expected 1", n);
        end
    endtask

    task automatic pulse_start_at(input int clk_no, ref int cur);
        while (cur < clk_no) begin tick(); cur++; end
        bus.op_start = 1'b1;
        bus.dividend = 64'd999;
        bus.divisor  = 64'd10;
        tick(); cur++;
        bus.op_start = 1'b0;
    endtask

    initial begin
        int n, cur, mode, sel;
        logic [W-1:0] a, b;

        bus.op_start = 1'b0;
        bus.op_clear = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset quotient", bus.quotient, '0);
        chk("reset op_done", W'(bus.op_done), '0);
        reset_n = 1'b1;
        tick();

        // 100/7 with exact latency
        start(64'd100, 64'd7);
        wait_done(0, n);
        chk("latency 100/7", W'(n), W'(LAT));
        chk("q 100/7", bus.quotient, 64'd14);
        chk("r 100/7", bus.remainder, 64'd2);
        chk("dz 100/7", W'(bus.div_by_zero), '0);
        clear_op(0);
        chk("q held after clear", bus.quotient, 64'd14);

        start('1, 64'd1);
        wait_done(0, n);
        chk("q ones/1", bus.quotient, '1);
        chk("r ones/1", bus.remainder, '0);
        clear_op(0);
        start(64'd5, 64'd9);
        wait_done(0, n);
        chk("q 5/9", bus.quotient, 64'd0);
        chk("r 5/9", bus.remainder, 64'd5);
        clear_op(1);

        // divide by zero
        start(64'h1234, 64'd0);
        wait_done(0, n);
        chk("latency div0", W'(n), '0);
        chk("q div0", bus.quotient, '1);
        chk("r div0", bus.remainder, 64'h1234);
        chk("dz div0", W'(bus.div_by_zero), 64'd1);
        clear_op(0);
        chk("dz cleared", W'(bus.div_by_zero), '0);

        // abort at clock 20 of EXEC
        start(64'd1000, 64'd3);
        repeat (19) tick();
        clear_op(0);
        chk("abort done", W'(bus.op_done), '0);
        chk("abort q", bus.quotient, '0);
        chk("abort r", bus.remainder, '0);
        repeat (LAT) tick();
        chk("abort done stays low", W'(bus.op_done), '0);
        start(64'd9, 64'd3);
        wait_done(0, n);
        chk("q 9/3", bus.quotient, 64'd3);
        chk("r 9/3", bus.remainder, 64'd0);
        clear_op(0);

        // op_start during EXEC is ignored
        start(64'd100, 64'd7);
        cur = 0;
        pulse_start_at(5, cur);
        pulse_start_at(30, cur);
        wait_done(0, n);
        chk("latency ignored start", W'(n + cur), W'(LAT));
        chk("q intact", bus.quotient, 64'd14);
        chk("r intact", bus.remainder, 64'd2);
        clear_op(0);

        // reset at clock 10
        start(64'd77, 64'd5);
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midreset q", bus.quotient, '0);
        chk("midreset done", W'(bus.op_done), '0);
        tick();

`ifdef SIGNED_DIV_EN
        start(-64'sd7, 64'd2);
        wait_done(0, n);
        chk("latency -7/2", W'(n), 64'd65);
        chk("q -7/2", bus.quotient, -64'sd3);
        chk("r -7/2", bus.remainder, -64'sd1);
        clear_op(0);
        start(64'h8000_0000_0000_0000, '1);
        wait_done(0, n);
        chk("q MIN/-1", bus.quotient, 64'h8000_0000_0000_0000);
        chk("r MIN/-1", bus.remainder, '0);
        clear_op(0);
`endif

        // randomized operations, checked every cycle by the model
        for (int it = 0; it < 40; it++) begin
            a = {$urandom, $urandom};
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = '0;
            else if (sel <= 3) b = W'($urandom_range(1, 20));
            else if (sel <= 5) b = {$urandom, $urandom} >> $urandom_range(0, 63);
            else               b = {$urandom, $urandom};
            mode = $urandom_range(0, 5);
            if (mode <= 2) begin
                start(a, b);
                wait_done(1, n);
                repeat ($urandom_range(0, 3)) tick();
                clear_op($urandom_range(0, 1) == 1);
            end else if (mode == 3) begin
                start(a, b);
                repeat ($urandom_range(1, LAT - 2)) tick();
                clear_op($urandom_range(0, 1) == 1);
            end else if (mode == 4) begin
                bus.dividend = a;
                bus.divisor  = b;
                clear_op(1);
                repeat (3) tick();
            end else begin
                start(a, b);
                repeat ($urandom_range(0, LAT)) tick();
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
                if (bus.op_done) clear_op(0);
            end
            tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
